afe_command_sequencer: RTL and testbench
========================================

AFE_COMMAND_SEQUENCER -- requirements
Module: afe_command_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving SPI half-period in clk cycles (legal values 1 to 255).
REQ-002 The block SHALL have parameter CS_GAP, default 8, giving the number of clk cycles spi_cs_n stays high between frames (legal values 1 to 255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to run the command list.
REQ-006 The block SHALL have port rom_address, output, 8 bits: command ROM read address.
REQ-007 The block SHALL have port rom_command, input, 24 bits: ROM word; [23:20] is the opcode and [19:0] is the SPI payload; it is valid one clk after rom_address changes.
REQ-008 The block SHALL have port spi_sclk, output, 1 bit: SPI clock, idle low.
REQ-009 The block SHALL have port spi_mosi, output, 1 bit: SPI data, MSB first.
REQ-010 The block SHALL have port spi_cs_n, output, 1 bit: chip select, active low.
REQ-011 The block SHALL have port busy, output, 1 bit: high while not in IDLE, DONE or ERROR.
REQ-012 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-013 The block SHALL have port error, output, 1 bit: high in ERROR.
REQ-014 The block SHALL have port cmd_count, output, 8 bits: number of frames completed since the last start.

Function
REQ-015 The block SHALL implement the states IDLE, FETCH, DECODE, SHIFT, GAP, DONE and ERROR.
REQ-016 In IDLE, DONE or ERROR, a start pulse SHALL clear rom_address and cmd_count to 0 and enter FETCH; start SHALL be ignored in every other state.
REQ-017 FETCH SHALL last exactly one cycle and then enter DECODE, which gives the ROM its read latency.
REQ-018 DECODE SHALL sample rom_command: opcode 4'h1 enters SHIFT, opcode 4'h0 enters DONE, and any other opcode enters ERROR; DECODE SHALL last one cycle.
REQ-019 On entry to SHIFT, the block SHALL load a 20-bit shift register with rom_command[19:0], drive spi_cs_n low, and drive spi_mosi to bit 19, all in the same cycle.
REQ-020 Each bit in SHIFT SHALL be sent as spi_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles (SPI mode 0).
REQ-021 spi_mosi SHALL change only on a falling spi_sclk edge or at frame start, and SHALL be stable during each high phase.
REQ-022 A frame SHALL contain exactly 20 rising spi_sclk edges.
REQ-023 After the 20th high phase, spi_sclk SHALL return low and be held low for CLK_DIV cycles, after which spi_cs_n SHALL rise and the block SHALL enter GAP.
REQ-024 The frame length, from spi_cs_n falling to spi_cs_n rising, SHALL be 41*CLK_DIV cycles.
REQ-025 On GAP entry, cmd_count SHALL increment, saturating at 255.
REQ-026 GAP SHALL hold spi_cs_n high for CS_GAP cycles.
REQ-027 At the end of GAP, if rom_address is 255 the block SHALL enter DONE, with no wrap-around; otherwise rom_address SHALL increment and the block SHALL enter FETCH.
REQ-028 While spi_cs_n is high, spi_sclk SHALL be low and spi_mosi SHALL be 0.
REQ-029 DONE and ERROR SHALL hold until the next start or reset; in ERROR, rom_address SHALL hold the address of the offending entry.
REQ-030 spi_sclk, spi_mosi and spi_cs_n SHALL be driven directly from flops.

Reset
REQ-031 While reset is high, the block SHALL be in IDLE with rom_address=0, cmd_count=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, busy=0, done=0 and error=0.
REQ-032 Reset asserted mid-frame SHALL raise spi_cs_n immediately (asynchronously), and the partial frame SHALL NOT be counted.
REQ-033 After reset is released, no SPI activity SHALL occur until a start pulse.

Verification
REQ-034 Bench, with ROM {0x112345, 0x1A5A5A, 0x000000}, CLK_DIV=4 and CS_GAP=8, start -> two frames with MOSI 0x12345 and 0xA5A5A, each 164 clk long with a 20-edge sclk; then done=1, cmd_count=2 and busy=0.
REQ-035 Bench, with ROM[0]=0x000000, start -> done=1 after 3 cycles, and spi_cs_n is never low.
REQ-036 Bench, with ROM {0x1FFFFF, 0x2ABCDE}, start -> one frame of all ones; then error=1, rom_address=1 and cmd_count=1.
REQ-037 Bench, reset asserted during bit 10 of the first frame -> spi_cs_n=1 in the same cycle and all outputs at their reset values; a subsequent start restarts from address 0.
REQ-038 Bench, start re-pulsed during SHIFT -> the frame is unaffected and the address sequence is unchanged.
REQ-039 Bench, with all 256 ROM entries at opcode 1 and CLK_DIV=1 -> 256 frames, each 41 cycles; then done=1, cmd_count=255 (saturated) and rom_address=255.

Source files
------------

// File: rtl/afe_command_sequencer.sv
// Walks a command ROM and plays every opcode-1 entry out as a 20-bit SPI mode-0 frame.
// The list ends on opcode 0 (DONE), on an illegal opcode (ERROR) or after address 255.
module afe_command_sequencer #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_address,
    input  logic [23:0] rom_command,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  cmd_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        SHIFT  = 3'd3,
        GAP    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [7:0] DIV_LAST     = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST     = 8'(CS_GAP - 1);
    // Half-phase index: even = sclk low, odd = sclk high, 40 = trailing low before cs_n rises
    localparam logic [5:0] PH_LAST      = 6'd40;
    localparam logic [5:0] PH_LAST_HIGH = 6'd39;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  div_cnt;
    logic [5:0]  ph_cnt;
    logic [7:0]  gap_cnt;
    logic [18:0] shift_sr;
    logic        div_last;
    logic        gap_last;
    logic        frame_end;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign div_last  = (div_cnt == DIV_LAST);
    assign gap_last  = (gap_cnt == GAP_LAST);
    assign frame_end = div_last && (ph_cnt == PH_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start)
                    state_nxt = FETCH;
            end
            FETCH: state_nxt = DECODE;
            DECODE: begin
                case (rom_command[23:20])
                    4'h1:    state_nxt = SHIFT;
                    4'h0:    state_nxt = DONE;
                    default: state_nxt = ERROR;
                endcase
            end
            SHIFT: begin
                if (frame_end)
                    state_nxt = GAP;
            end
            GAP: begin
                if (gap_last)
                    state_nxt = (rom_address == 8'hFF) ? DONE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        error = 1'b0;
        case (state)
            IDLE:    ;
            DONE:    done  = 1'b1;
            ERROR:   error = 1'b1;
            default: busy  = 1'b1;
        endcase
    end

    // Control, counters and the SPI pins; the pins are registered so they never glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_address <= 8'd0;
            cmd_count   <= 8'd0;
            spi_sclk    <= 1'b0;
            spi_mosi    <= 1'b0;
            spi_cs_n    <= 1'b1;
            div_cnt     <= 8'd0;
            ph_cnt      <= 6'd0;
            gap_cnt     <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        rom_address <= 8'd0;
                        cmd_count   <= 8'd0;
                    end
                end
                DECODE: begin
                    if (rom_command[23:20] == 4'h1) begin
                        spi_cs_n <= 1'b0;
                        spi_sclk <= 1'b0;
                        spi_mosi <= rom_command[19];
                        div_cnt  <= 8'd0;
                        ph_cnt   <= 6'd0;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= 8'd0;
                        ph_cnt  <= ph_cnt + 6'd1;
                        if (ph_cnt == PH_LAST) begin
                            spi_cs_n  <= 1'b1;
                            spi_mosi  <= 1'b0;
                            cmd_count <= sat_inc(cmd_count);
                            gap_cnt   <= 8'd0;
                        end else if (!ph_cnt[0]) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            spi_sclk <= 1'b0;
                            if (ph_cnt != PH_LAST_HIGH)
                                spi_mosi <= shift_sr[18];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        if (rom_address != 8'hFF)
                            rom_address <= rom_address + 8'd1;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Remaining payload bits after bit 19 has gone straight to spi_mosi
    always_ff @(posedge clk) begin
        if (state == DECODE)
            shift_sr <= rom_command[18:0];
        else if (state == SHIFT && div_last && ph_cnt[0])
            shift_sr <= {shift_sr[17:0], 1'b0};
    end

endmodule

// File: tb/tb_afe_command_sequencer.sv
// Scoreboard bench for afe_command_sequencer: instance a runs CLK_DIV=4, instance b CLK_DIV=1.
module tb_afe_command_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [7:0]  addr_a, addr_b;
    logic [23:0] cmd_a, cmd_b;
    logic        sclk_a, sclk_b, mosi_a, mosi_b, cs_a, cs_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [7:0]  cnt_a, cnt_b;

    logic [23:0] rom_a [256];
    logic [23:0] rom_b [256];

    logic [19:0] exp_a [$];
    logic [19:0] exp_b [$];

    int n_checks = 0;
    int n_fail   = 0;

    bit          in_frame    [2];
    bit          prev_sck    [2];
    int          len         [2];
    int          edges       [2];
    logic [19:0] shr         [2];
    logic        hold        [2];
    bit          bad         [2];
    bit          idle_bad    [2];
    int          frames_seen [2];

    always #5 clk = ~clk;

    afe_command_sequencer #(.CLK_DIV(4), .CS_GAP(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .rom_address(addr_a),
        .rom_command(cmd_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_cs_n(cs_a),
        .busy(busy_a), .done(done_a), .error(err_a), .cmd_count(cnt_a)
    );

    afe_command_sequencer #(.CLK_DIV(1), .CS_GAP(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .rom_address(addr_b),
        .rom_command(cmd_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_cs_n(cs_b),
        .busy(busy_b), .done(done_b), .error(err_b), .cmd_count(cnt_b)
    );

    // Synchronous ROM: data follows the address by one clock
    always @(posedge clk) begin
        cmd_a <= rom_a[addr_a];
        cmd_b <= rom_b[addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input int idx, input logic cs, input logic sck, input logic mo);
        logic [19:0] e;
        bit          have;
        int          div;
        div  = (idx == 0) ? 4 : 1;
        have = 1'b0;
        e    = 20'd0;
        if (reset) begin
            in_frame[idx] = 1'b0;
            prev_sck[idx] = 1'b0;
        end else if (cs) begin
            if (sck !== 1'b0 || mo !== 1'b0)
                idle_bad[idx] = 1'b1;
            if (in_frame[idx]) begin
                if (idx == 0) begin
                    if (exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
                end else begin
                    if (exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
                end
                if (!have) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame dut%0d: got payload 0x%0h, expected no frame", idx, shr[idx]);
                end else begin
                    check("frame_payload", 32'(shr[idx]), 32'(e));
                    check("frame_sclk_edges", 32'(edges[idx]), 32'd20);
                    check("frame_length", 32'(len[idx]), 32'(41 * div));
                    check("mosi_stable_high", 32'(bad[idx]), 32'd0);
                end
            end
            in_frame[idx] = 1'b0;
            prev_sck[idx] = sck;
        end else begin
            if (!in_frame[idx]) begin
                in_frame[idx] = 1'b1;
                frames_seen[idx]++;
                len[idx]   = 0;
                edges[idx] = 0;
                shr[idx]   = 20'd0;
                bad[idx]   = 1'b0;
            end
            len[idx]++;
            if (sck && !prev_sck[idx]) begin
                edges[idx]++;
                shr[idx]  = {shr[idx][18:0], mo};
                hold[idx] = mo;
            end else if (sck && mo !== hold[idx]) begin
                bad[idx] = 1'b1;
            end
            prev_sck[idx] = sck;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, cs_a, sclk_a, mosi_a);
        mon_step(1, cs_b, sclk_b, mosi_b);
    end

    task automatic pulse(input int idx);
        @(negedge clk);
        if (idx == 0) start_a = 1'b1;
        else          start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input int idx, input int budget, input string name);
        int t = 0;
        while (((idx == 0) ? busy_a : busy_b) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(t < budget), 32'd1);
    endtask

    task automatic wait_cs_low(input int budget, input string name);
        int t = 0;
        while (cs_a && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(t < budget), 32'd1);
    endtask

    task automatic load_basic_rom;
        for (int i = 0; i < 256; i++) rom_a[i] = 24'h000000;
        rom_a[0] = 24'h112345;
        rom_a[1] = 24'h1A5A5A;
        rom_a[2] = 24'h000000;
    endtask

    initial begin
        int fs;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        load_basic_rom();
        for (int i = 0; i < 256; i++) rom_b[i] = {4'h1, 20'(i * 4099) ^ 20'h5A5A5};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_mosi", 32'(mosi_a), 32'd0);
        check("rst_cs_n", 32'(cs_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_error", 32'(err_a), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("no_activity_before_start", 32'(frames_seen[0]), 32'd0);

        // Two frames then end-of-list
        exp_a.push_back(20'h12345);
        exp_a.push_back(20'hA5A5A);
        pulse(0);
        wait_idle(0, 2000, "basic_timeout");
        check("basic_done", 32'(done_a), 32'd1);
        check("basic_count", 32'(cnt_a), 32'd2);
        check("basic_busy", 32'(busy_a), 32'd0);
        check("basic_error", 32'(err_a), 32'd0);
        check("basic_addr", 32'(addr_a), 32'd2);
        check("basic_frames", 32'(frames_seen[0]), 32'd2);
        check("basic_pending", 32'(exp_a.size()), 32'd0);

        // Empty list: done three cycles after start, cs_n never low
        rom_a[0] = 24'h000000;
        fs = frames_seen[0];
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("empty_fetch_done", 32'(done_a), 32'd0);
        check("empty_fetch_count_cleared", 32'(cnt_a), 32'd0);
        @(negedge clk);
        check("empty_decode_done", 32'(done_a), 32'd0);
        @(negedge clk);
        check("empty_done", 32'(done_a), 32'd1);
        check("empty_busy", 32'(busy_a), 32'd0);
        repeat (5) @(negedge clk);
        check("empty_no_frame", 32'(frames_seen[0] - fs), 32'd0);

        // Illegal opcode after one all-ones frame
        rom_a[0] = 24'h1FFFFF;
        rom_a[1] = 24'h2ABCDE;
        exp_a.push_back(20'hFFFFF);
        pulse(0);
        wait_idle(0, 2000, "error_timeout");
        check("error_flag", 32'(err_a), 32'd1);
        check("error_done", 32'(done_a), 32'd0);
        check("error_addr", 32'(addr_a), 32'd1);
        check("error_count", 32'(cnt_a), 32'd1);
        check("error_pending", 32'(exp_a.size()), 32'd0);
        repeat (5) @(negedge clk);
        check("error_hold", 32'(err_a), 32'd1);

        // Reset in the middle of bit 10 of the first frame
        load_basic_rom();
        pulse(0);
        wait_cs_low(100, "midreset_cs_timeout");
        repeat (82) @(negedge clk);
        fs = frames_seen[0];
        #2 reset = 1'b1;
        #1;
        check("midreset_cs_n", 32'(cs_a), 32'd1);
        check("midreset_sclk", 32'(sclk_a), 32'd0);
        check("midreset_mosi", 32'(mosi_a), 32'd0);
        check("midreset_busy", 32'(busy_a), 32'd0);
        check("midreset_done", 32'(done_a), 32'd0);
        check("midreset_error", 32'(err_a), 32'd0);
        check("midreset_addr", 32'(addr_a), 32'd0);
        check("midreset_count", 32'(cnt_a), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("postreset_no_frame", 32'(frames_seen[0] - fs), 32'd0);
        check("postreset_cs_n", 32'(cs_a), 32'd1);
        exp_a.push_back(20'h12345);
        exp_a.push_back(20'hA5A5A);
        pulse(0);
        wait_idle(0, 2000, "restart_timeout");
        check("restart_done", 32'(done_a), 32'd1);
        check("restart_count", 32'(cnt_a), 32'd2);
        check("restart_addr", 32'(addr_a), 32'd2);
        check("restart_pending", 32'(exp_a.size()), 32'd0);

        // Start re-pulsed during SHIFT is ignored
        exp_a.push_back(20'h12345);
        exp_a.push_back(20'hA5A5A);
        pulse(0);
        wait_cs_low(100, "repulse_cs_timeout");
        repeat (30) @(negedge clk);
        pulse(0);
        repeat (150) @(negedge clk);
        pulse(0);
        wait_idle(0, 2000, "repulse_timeout");
        check("repulse_done", 32'(done_a), 32'd1);
        check("repulse_count", 32'(cnt_a), 32'd2);
        check("repulse_addr", 32'(addr_a), 32'd2);
        check("repulse_pending", 32'(exp_a.size()), 32'd0);
        check("idle_lines_a", 32'(idle_bad[0]), 32'd0);

        // Full 256-entry list at CLK_DIV=1
        for (int i = 0; i < 256; i++) exp_b.push_back(rom_b[i][19:0]);
        pulse(1);
        wait_idle(1, 20000, "full_timeout");
        check("full_done", 32'(done_b), 32'd1);
        check("full_count_saturated", 32'(cnt_b), 32'd255);
        check("full_addr", 32'(addr_b), 32'd255);
        check("full_error", 32'(err_b), 32'd0);
        check("full_frames", 32'(frames_seen[1]), 32'd256);
        check("full_pending", 32'(exp_b.size()), 32'd0);
        check("idle_lines_b", 32'(idle_bad[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
